// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Turns a first-word-fall-through FIFO read port into a valid/ready stream.
//   Words pass through a 2-entry buffer: the main register drives out_data and
//   a skid register catches the word popped in the cycle the sink stalls. The
//   FIFO read enable depends only on registered state, fifo_empty, flush and
//   rst, so out_ready has no combinational path to fifo_en_r.
//
//   Optional feature: define FIFO_RD_STAT_EN to build the word/stall counters.
//   Without it both counter ports are tied to zero and no counter registers
//   are built.
//
// Ports
//   clk         in   clock, all logic on its rising edge
//   rst         in   synchronous active-high reset, overrides everything
//   fifo_data   in   FIFO head word, valid while fifo_empty = 0
//   fifo_empty  in   FIFO empty flag
//   fifo_en_r   out  FIFO pop strobe
//   flush       in   drop every buffered word this cycle
//   out_valid   out  out_data holds a word
//   out_ready   in   sink takes the word this cycle
//   out_data    out  stream word (main register)
//   word_count  out  words handed to the sink (16-bit, wraps)
//   stall_count out  cycles with out_valid=1 and out_ready=0 (saturates)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
   parameter int DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_en_r,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic [15:0]          word_count,
   output logic [15:0]          stall_count
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] ONE  = 2'b01;
   localparam logic [1:0] TWO  = 2'b10;

   logic [1:0]           state_q, state_d;
   logic [DATA_BITS-1:0] main_q,  main_d;
   logic [DATA_BITS-1:0] skid_q,  skid_d;
   logic                 pop;
   logic                 xfer;

   // Read enable is blocked while both entries are full, during flush and
   // during the reset cycle.
   assign pop       = ~rst & ~fifo_empty & ~flush & (state_q != TWO);
   assign fifo_en_r = pop;
   assign out_valid = (state_q != IDLE);
   assign out_data  = main_q;
   // A flush cycle never hands a word to the sink.
   assign xfer      = out_valid & out_ready & ~flush;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = fifo_data;
               end
            end
            ONE: begin
               if (pop && xfer) begin
                  main_d  = fifo_data;
               end else if (pop) begin
                  state_d = TWO;
                  skid_d  = fifo_data;
               end else if (xfer) begin
                  state_d = IDLE;
               end
            end
            TWO: begin
               if (xfer) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef FIFO_RD_STAT_EN
   logic [15:0] word_q,  word_d;
   logic [15:0] stall_q, stall_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Counters survive flush; only rst clears them.
   always_comb begin
      word_d  = word_q;
      stall_d = stall_q;
      if (xfer) begin
         word_d = word_q + 16'd1;
      end
      if (out_valid && !out_ready) begin
         stall_d = sat_inc16(stall_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         stall_q <= '0;
      end else begin
         word_q  <= word_d;
         stall_q <= stall_d;
      end
   end

   assign word_count  = word_q;
   assign stall_count = stall_q;
`else
   assign word_count  = '0;
   assign stall_count = '0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_BITS, default 32, data word width.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 fifo_data  input  DATA_BITS  FIFO head word, valid whenever fifo_empty=0 (first-word-fall-through).
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_en_r  output  1  FIFO read enable (pop).
REQ-007 flush  input  1  discard all buffered words.
REQ-008 out_valid  output  1  out_data holds a word.
REQ-009 out_ready  input  1  sink accepts the word this cycle.
REQ-010 out_data  output  DATA_BITS  stream data, registered.
REQ-011 word_count  output  16  accepted-word count (see Configuration).
REQ-012 stall_count  output  16  stalled-cycle count (see Configuration).

Function
REQ-013 The block SHALL convert the FIFO read interface into a valid/ready stream through a 2-entry buffer: main register (drives out_data) and skid register.
REQ-014 The state machine SHALL have states IDLE (no word), ONE (main valid), TWO (main and skid valid); out_valid = (state != IDLE).
REQ-015 fifo_en_r SHALL equal ~fifo_empty & ~flush & (state != TWO), with no combinational path from out_ready.
REQ-016 A pop is a cycle with fifo_en_r=1; the popped word is fifo_data sampled in that cycle.
REQ-017 Transfer is a cycle with out_valid=1 and out_ready=1.
REQ-018 IDLE: pop -> ONE, main <= fifo_data; otherwise stay IDLE.
REQ-019 ONE: pop and transfer -> ONE, main <= fifo_data; pop, no transfer -> TWO, skid <= fifo_data; transfer, no pop -> IDLE; neither -> ONE, main held.
REQ-020 TWO: transfer -> ONE, main <= skid; no transfer -> TWO, main and skid held.
REQ-021 Latency: a word at the FIFO head in IDLE with fifo_empty=0 SHALL appear on out_data with out_valid=1 one cycle later.
REQ-022 Sustained throughput SHALL be one word per cycle while fifo_empty=0 and out_ready=1.
REQ-023 Word order SHALL be preserved, and no word SHALL be duplicated or dropped except by flush or rst.
REQ-024 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 SHALL force the next state to IDLE, with no pop and no transfer counted that cycle; flush takes priority over out_ready.
REQ-026 If fifo_empty=1 in ONE, the block SHALL drain without popping.
REQ-027 out_data in IDLE SHALL hold its last value, which is don't-care.

Reset
REQ-028 rst SHALL take priority over flush and all other inputs.
REQ-029 On rst: state=IDLE, out_valid=0, fifo_en_r=0 during the rst cycle, out_data=0, skid=0, word_count=0, stall_count=0.
REQ-030 rst asserted mid-operation SHALL discard buffered words; FIFO words not yet popped are unaffected.

Configuration
REQ-031 Macro FIFO_RD_STAT_EN SHALL select the statistics feature.
REQ-032 With FIFO_RD_STAT_EN defined, word_count SHALL increment by 1 per transfer (16-bit, wraps 0xFFFF->0).
REQ-033 With FIFO_RD_STAT_EN defined, stall_count SHALL increment by 1 per cycle with out_valid=1 and out_ready=0, saturating at 0xFFFF.
REQ-034 Both counters SHALL clear on rst only, not on flush.
REQ-035 Without FIFO_RD_STAT_EN, word_count and stall_count SHALL be constant 0 with no counter registers; the ports remain present.

Verification
REQ-036 Reset, then FIFO holds 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on 3 consecutive cycles starting 1 cycle after reset release; word_count=3.
REQ-037 FIFO holds 0xA0..0xA3, out_ready=0 for 5 cycles -> exactly 2 pops, state TWO, out_data=0xA0 stable, stall_count=4; then out_ready=1 -> 0xA0,0xA1,0xA2,0xA3 in order with no gaps.
REQ-038 In TWO, pulse flush for 1 cycle -> out_valid=0 the next cycle, fifo_en_r=0 during flush; next FIFO word appears 2 cycles after flush.
REQ-039 Random fifo_empty and out_ready toggling over 1000 words 0..999 -> sink receives 0..999 exactly in order, fifo_en_r never asserted while fifo_empty=1 or in TWO.
REQ-040 FIFO_RD_STAT_EN defined, 65537 transfers -> word_count=1; out_ready=0 held 70000 cycles with out_valid=1 -> stall_count=0xFFFF.
REQ-041 rst asserted while in TWO with out_ready=1 -> out_valid=0 and both counters 0 the following cycle.
